uart_rx_core: RTL and testbench

- 8N1 UART receiver driven by the 16x-oversample enable from the baud rate generator (`rxclk_en_o` -> `rxclk_en_i`).
- Synchronises the asynchronous rx line and validates the start bit at mid-bit.
- Samples data and stop bits at their centres.
- Hands each byte to the host-side UART register block over a valid/ready handshake, with framing-error and overrun reporting.

---
 rtl/uart_rx_core.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_core.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x-oversampled, start bit validated at mid-bit, data and stop
// sampled at bit centres, byte handed off over valid/ready with framing/overrun pulses.
`timescale 1ns/1ps
module uart_rx_core #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned TICK_WIDTH = $clog2(OVERSAMPLE)
) (
    input  logic                 clk_50m_i,
    input  logic                 rst_n_i,
    input  logic                 rxclk_en_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    input  logic                 data_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS) + 1;

    localparam logic [TICK_WIDTH-1:0] TICK_MID  = TICK_WIDTH'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_WIDTH-1:0] TICK_LAST = TICK_WIDTH'(OVERSAMPLE - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_DONE  = BIT_CNT_W'(DATA_BITS);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic                  rx_meta_q;
    logic                  rx_s_q;

    logic [2:0]            state_q,    state_d;
    logic [TICK_WIDTH-1:0] tick_cnt_q, tick_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q,    shift_d;

    logic [DATA_BITS-1:0]  data_q,       data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  frame_err_q,  frame_err_d;
    logic                  overrun_q,    overrun_d;
    logic                  busy_q,       busy_d;

    logic                  byte_done;
    logic                  stop_err;
    logic                  handshake;

    always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Bits enter at the MSB and shift down, so after DATA_BITS samples bit 0 sits at the LSB.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        byte_done  = 1'b0;
        stop_err   = 1'b0;

        if (rxclk_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = S_START;
                        tick_cnt_d = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        if (!rx_s_q) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_d == BIT_DONE) begin
                            state_d   = S_STOP;
                            bit_cnt_d = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (rx_s_q) begin
                            byte_done = 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            stop_err  = 1'b1;
                            state_d   = S_WAIT_HIGH;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // A load and a handshake in the same cycle keep valid high: the old byte was taken.
    always_comb begin
        handshake    = data_valid_q & data_ready_i;
        data_d       = byte_done ? shift_q : data_q;
        data_valid_d = byte_done | (data_valid_q & ~data_ready_i);
        frame_err_d  = stop_err;
        overrun_d    = byte_done & data_valid_q & ~handshake;
        busy_d       = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign frame_err_o  = frame_err_q;
    assign overrun_o    = overrun_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: scoreboard of sent bytes, popped on delivery.
`timescale 1ns/1ps
module tb_uart_rx_core;

    logic       clk_50m_i = 1'b0;
    logic       rst_n_i;
    logic       rxclk_en_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       data_valid_o;
    logic       data_ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    int en_div    = 1;
    int en_cnt    = 0;
    int cyc       = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int busy_cnt  = 0;
    int start_cyc = 0;

    logic [7:0] sb[$];

    uart_rx_core #(
        .DATA_BITS (8),
        .OVERSAMPLE(16)
    ) dut (
        .clk_50m_i   (clk_50m_i),
        .rst_n_i     (rst_n_i),
        .rxclk_en_i  (rxclk_en_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #10 clk_50m_i = ~clk_50m_i;

    always @(posedge clk_50m_i) begin
        cyc <= cyc + 1;
        if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
        if (overrun_o)   ovr_cnt  <= ovr_cnt + 1;
        if (busy_o)      busy_cnt <= busy_cnt + 1;
    end

    always @(negedge clk_50m_i) begin
        if (en_div <= 1) begin
            rxclk_en_i <= 1'b1;
            en_cnt     <= 0;
        end else begin
            rxclk_en_i <= (en_cnt == 0);
            en_cnt     <= (en_cnt >= en_div - 1) ? 0 : en_cnt + 1;
        end
    end

    // Called at a negedge; start bit is driven immediately.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [7:0] v;
        v = b;
        start_cyc = cyc;
        rx_i = 1'b0;
        repeat (16 * en_div) @(negedge clk_50m_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = v[i];
            repeat (16 * en_div) @(negedge clk_50m_i);
        end
        rx_i = stop_bit;
        repeat (16 * en_div) @(negedge clk_50m_i);
    endtask

    task automatic wait_valid(input int limit, output bit timed_out, output int at_cyc);
        timed_out = 1'b1;
        at_cyc    = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_50m_i);
            if (data_valid_o) begin
                timed_out = 1'b0;
                at_cyc    = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0; rx_i = 1'b1; data_ready_i = 1'b0;
        repeat (4) @(negedge clk_50m_i);
        checks++;
        if ({data_o, data_valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got data=%h valid=%b ferr=%b ovr=%b busy=%b, required all 0",
                     data_o, data_valid_o, frame_err_o, overrun_o, busy_o);
        end
        rst_n_i = 1'b1;
        repeat (8) @(negedge clk_50m_i);
        checks++;
        if (data_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got valid=%b busy=%b, required 0 0", data_valid_o, busy_o);
        end
    endtask

    task automatic test_basic_frame();
        bit to; int at; int f0, o0; logic [7:0] exp;
        data_ready_i = 1'b0; f0 = ferr_cnt; o0 = ovr_cnt;
        sb.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            wait_valid(400, to, at);
        join
        checks++;
        if (to) begin failures++; $display("FAIL basic_valid_timeout: valid=0, required 1"); end
        checks++;
        if (at - start_cyc != 155) begin
            failures++; $display("FAIL basic_latency: got %0d clocks, required 155", at - start_cyc);
        end
        exp = sb.pop_front();
        checks++;
        if (data_o !== exp || data_valid_o !== 1'b1) begin
            failures++; $display("FAIL basic_data: got %h valid=%b, required %h valid=1", data_o, data_valid_o, exp);
        end
        checks++;
        if (ferr_cnt != f0 || ovr_cnt != o0) begin
            failures++; $display("FAIL basic_no_err: got ferr=%0d ovr=%0d pulses, required 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
        data_ready_i = 1'b1;
        @(negedge clk_50m_i);
        data_ready_i = 1'b0;
        checks++;
        if (data_valid_o !== 1'b0) begin
            failures++; $display("FAIL basic_handshake: got valid=%b, required 0", data_valid_o);
        end
    endtask

    task automatic test_glitch();
        int b0, f0;
        b0 = busy_cnt; f0 = ferr_cnt;
        data_ready_i = 1'b1;
        rx_i = 1'b0;
        repeat (4) @(negedge clk_50m_i);
        rx_i = 1'b1;
        repeat (30) @(negedge clk_50m_i);
        data_ready_i = 1'b0;
        checks++;
        if (busy_cnt - b0 != 8) begin
            failures++; $display("FAIL glitch_busy_len: got %0d busy cycles, required 8", busy_cnt - b0);
        end
        checks++;
        if (data_valid_o !== 1'b0 || busy_o !== 1'b0 || ferr_cnt != f0) begin
            failures++; $display("FAIL glitch_quiet: got valid=%b busy=%b ferr=%0d, required 0 0 0",
                                 data_valid_o, busy_o, ferr_cnt - f0);
        end
    endtask

    task automatic test_frame_error();
        bit to; int at; int f0, o0; logic [7:0] exp;
        f0 = ferr_cnt; o0 = ovr_cnt; data_ready_i = 1'b0;
        send_frame(8'h3C, 1'b0);
        repeat (40 * 16) @(negedge clk_50m_i);
        rx_i = 1'b1;
        repeat (32) @(negedge clk_50m_i);
        checks++;
        if (ferr_cnt - f0 != 1) begin
            failures++; $display("FAIL ferr_count: got %0d cycles of frame_err_o, required 1", ferr_cnt - f0);
        end
        checks++;
        if (data_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++; $display("FAIL ferr_discard: got valid=%b busy=%b, required 0 0", data_valid_o, busy_o);
        end
        sb.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1);
            wait_valid(400, to, at);
        join
        exp = sb.pop_front();
        checks++;
        if (to || data_o !== exp) begin
            failures++; $display("FAIL ferr_recover: got %h timeout=%b, required %h", data_o, to, exp);
        end
        checks++;
        if (ferr_cnt - f0 != 1 || ovr_cnt != o0) begin
            failures++; $display("FAIL ferr_recover_clean: got ferr=%0d ovr=%0d, required 1 0", ferr_cnt - f0, ovr_cnt - o0);
        end
        data_ready_i = 1'b1;
        @(negedge clk_50m_i);
        data_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int o0; logic [7:0] exp;
        o0 = ovr_cnt; data_ready_i = 1'b0;
        sb.push_back(8'h11); sb.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (3) @(negedge clk_50m_i);
        checks++;
        if (ovr_cnt - o0 != 1) begin
            failures++; $display("FAIL overrun_count: got %0d cycles of overrun_o, required 1", ovr_cnt - o0);
        end
        void'(sb.pop_front());
        exp = sb.pop_front();
        checks++;
        if (data_o !== exp || data_valid_o !== 1'b1) begin
            failures++; $display("FAIL overrun_data: got %h valid=%b, required %h valid=1", data_o, data_valid_o, exp);
        end
        data_ready_i = 1'b1;
        @(negedge clk_50m_i);
        data_ready_i = 1'b0;

        o0 = ovr_cnt;
        sb.push_back(8'h33); sb.push_back(8'h44);
        send_frame(8'h33, 1'b1);
        fork
            send_frame(8'h44, 1'b1);
            begin
                repeat (154) @(negedge clk_50m_i);
                exp = sb.pop_front();
                checks++;
                if (data_o !== exp || data_valid_o !== 1'b1) begin
                    failures++; $display("FAIL same_cycle_old: got %h valid=%b, required %h valid=1", data_o, data_valid_o, exp);
                end
                data_ready_i = 1'b1;
                @(negedge clk_50m_i);
                data_ready_i = 1'b0;
                checks++;
                if (data_o !== sb[0] || data_valid_o !== 1'b1) begin
                    failures++; $display("FAIL same_cycle_new: got %h valid=%b, required %h valid=1", data_o, data_valid_o, sb[0]);
                end
            end
        join
        repeat (3) @(negedge clk_50m_i);
        checks++;
        if (ovr_cnt != o0) begin
            failures++; $display("FAIL same_cycle_no_ovr: got %0d overrun cycles, required 0", ovr_cnt - o0);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit to; int at; logic [7:0] exp;
        // 0x96 LSB first: start, 0, 1, 1, then half of bit 3 (0)
        rx_i = 1'b0; repeat (16) @(negedge clk_50m_i);
        rx_i = 1'b0; repeat (16) @(negedge clk_50m_i);
        rx_i = 1'b1; repeat (32) @(negedge clk_50m_i);
        rx_i = 1'b0; repeat (8)  @(negedge clk_50m_i);
        checks++;
        if (busy_o !== 1'b1 || data_valid_o !== 1'b1) begin
            failures++; $display("FAIL pre_reset_state: got busy=%b valid=%b, required 1 1", busy_o, data_valid_o);
        end
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({data_o, data_valid_o, frame_err_o, overrun_o, busy_o} !== 12'h000) begin
            failures++; $display("FAIL async_reset: got data=%h valid=%b ferr=%b ovr=%b busy=%b, required all 0",
                                 data_o, data_valid_o, frame_err_o, overrun_o, busy_o);
        end
        sb.delete();
        rx_i = 1'b1;
        repeat (5) @(negedge clk_50m_i);
        rst_n_i = 1'b1;
        repeat (40) @(negedge clk_50m_i);
        checks++;
        if (data_valid_o !== 1'b0) begin
            failures++; $display("FAIL no_partial_byte: got valid=%b, required 0", data_valid_o);
        end
        sb.push_back(8'hF0);
        fork
            send_frame(8'hF0, 1'b1);
            wait_valid(400, to, at);
        join
        exp = sb.pop_front();
        checks++;
        if (to || data_o !== exp) begin
            failures++; $display("FAIL post_reset_data: got %h timeout=%b, required %h", data_o, to, exp);
        end
        data_ready_i = 1'b1;
        @(negedge clk_50m_i);
        data_ready_i = 1'b0;
    endtask

    task automatic test_slow_tick();
        int f0, o0;
        en_div = 27;
        repeat (60) @(negedge clk_50m_i);
        f0 = ferr_cnt; o0 = ovr_cnt; data_ready_i = 1'b0;
        sb.push_back(8'h00); sb.push_back(8'hFF);
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    bit to; int at, dev; logic [7:0] exp;
                    wait_valid(6000, to, at);
                    dev = (at - start_cyc) - 152 * 27;
                    exp = sb.pop_front();
                    checks++;
                    if (to || data_o !== exp) begin
                        failures++; $display("FAIL slow_data%0d: got %h timeout=%b, required %h", k, data_o, to, exp);
                    end
                    checks++;
                    if (dev < -30 || dev > 30) begin
                        failures++; $display("FAIL slow_centre%0d: got %0d clocks from stop centre, required within 30", k, dev);
                    end
                    data_ready_i = 1'b1;
                    @(negedge clk_50m_i);
                    data_ready_i = 1'b0;
                end
            end
        join
        repeat (3) @(negedge clk_50m_i);
        checks++;
        if (ferr_cnt != f0 || ovr_cnt != o0) begin
            failures++; $display("FAIL slow_no_err: got ferr=%0d ovr=%0d, required 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end
        en_div = 1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        rxclk_en_i = 1'b1;
        rx_i = 1'b1;
        data_ready_i = 1'b0;
        rst_n_i = 1'b0;
        @(negedge clk_50m_i);
        test_reset();
        test_basic_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_slow_tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
